// File: rtl/frame_timer_pkg.sv
// Shared types and constants for the frame phase timer.
// Latency: n/a. Backpressure: n/a.
package frame_timer_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int DEF_PERIOD_16MS = 800000;
    localparam int MIN_PERIOD      = 2;

endpackage

// File: rtl/phase_window.sv
// One phase-window channel: set on the on-count, clear on the off-count, off has priority.
// Latency: 1 cycle from counter match to win. Backpressure: none, free-running strobe.
module phase_window #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             eval,
    input  logic             clr,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] on_val,
    input  logic [CNT_W-1:0] off_val,
    output logic             win
);

    logic on_hit;
    logic off_hit;

    // Compare values outside the frame can never be reached by cnt; gate them explicitly anyway.
    assign on_hit  = (cnt == on_val)  && (on_val  < period);
    assign off_hit = (cnt == off_val) && (off_val < period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= 1'b0;
        end else if (clr) begin
            win <= 1'b0;
        end else if (eval) begin
            if (off_hit) begin
                win <= 1'b0;
            end else if (on_hit) begin
                win <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_phase_timer.sv
// Frame-period generator with runtime period, free-run/one-shot, resync and N phase windows.
// Latency: outputs registered, 1 cycle after the counter event. Backpressure: none.
module frame_phase_timer
    import frame_timer_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int N_CH       = 4,
    parameter int DEF_PERIOD = DEF_PERIOD_16MS,
    parameter int FCNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  trig,
    input  logic                  period_ld,
    input  logic [CNT_W-1:0]      period_in,
    input  logic [N_CH*CNT_W-1:0] ch_on,
    input  logic [N_CH*CNT_W-1:0] ch_off,
    output logic [N_CH-1:0]       ch_out,
    output logic                  frame_tick,
    output logic                  busy,
    output logic [FCNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]      cur_cnt
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] pend;
    logic             pend_v;
    logic [CNT_W-1:0] ld_val;

    logic run;
    logic wrap;
    logic resync;
    logic start;
    logic ch_clr;

    assign ld_val = (period_in < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_in;

    // A trig landing on the wrap cycle is absorbed by the wrap, so resync excludes it.
    always_comb begin
        run    = (state == RUN);
        wrap   = run && en && (cnt == period_reg - CNT_W'(1));
        resync = run && en && !mode && trig && !wrap;
        start  = !run && en && (!mode || trig);
        ch_clr = !en || !run || resync || (wrap && mode);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            period_reg <= CNT_W'(DEF_PERIOD);
            pend       <= CNT_W'(DEF_PERIOD);
            pend_v     <= 1'b0;
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (period_ld) begin
                pend   <= ld_val;
                pend_v <= 1'b1;
            end
            if (state == IDLE) begin
                if (start) begin
                    state      <= RUN;
                    cnt        <= '0;
                    frame_tick <= 1'b1;
                    busy       <= 1'b1;
                end else begin
                    frame_tick <= 1'b0;
                end
            end else if (wrap || resync) begin
                // A load in this very cycle takes effect at this boundary.
                if (period_ld) begin
                    period_reg <= ld_val;
                end else if (pend_v) begin
                    period_reg <= pend;
                end
                pend_v <= 1'b0;
                cnt    <= '0;
                if (wrap) begin
                    frame_cnt <= frame_cnt + FCNT_W'(1);
                end
                if (wrap && mode) begin
                    state      <= IDLE;
                    frame_tick <= 1'b0;
                    busy       <= 1'b0;
                end else begin
                    frame_tick <= 1'b1;
                end
            end else begin
                cnt        <= cnt + CNT_W'(1);
                frame_tick <= 1'b0;
            end
        end
    end

    assign cur_cnt = cnt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        phase_window #(.CNT_W(CNT_W)) u_win (
            .clk     (clk),
            .rst_n   (rst_n),
            .eval    (run),
            .clr     (ch_clr),
            .cnt     (cnt),
            .period  (period_reg),
            .on_val  (ch_on[i*CNT_W +: CNT_W]),
            .off_val (ch_off[i*CNT_W +: CNT_W]),
            .win     (ch_out[i])
        );
    end

endmodule

// File: tb/tb_frame_phase_timer.sv
// Scoreboard bench for frame_phase_timer against an event-level reference model.
module tb_frame_phase_timer;

    localparam int CNT_W  = 32;
    localparam int N_CH   = 4;
    localparam int DEFP   = 40;
    localparam int FCNT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic                  mode = 1'b0;
    logic                  trig = 1'b0;
    logic                  period_ld = 1'b0;
    logic [CNT_W-1:0]      period_in = '0;
    logic [N_CH*CNT_W-1:0] ch_on = '0;
    logic [N_CH*CNT_W-1:0] ch_off = '0;
    logic [N_CH-1:0]       ch_out;
    logic                  frame_tick;
    logic                  busy;
    logic [FCNT_W-1:0]     frame_cnt;
    logic [CNT_W-1:0]      cur_cnt;

    frame_phase_timer #(.CNT_W(CNT_W), .N_CH(N_CH), .DEF_PERIOD(DEFP), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .trig(trig),
        .period_ld(period_ld), .period_in(period_in), .ch_on(ch_on), .ch_off(ch_off),
        .ch_out(ch_out), .frame_tick(frame_tick), .busy(busy),
        .frame_cnt(frame_cnt), .cur_cnt(cur_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH-1:0] ch;
        logic            tick;
        logic            busy;
        longint          fc;
        longint          cnt;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference state: frame position, period bookkeeping and per-channel event time stamps.
    bit     m_run;
    longint m_cnt, m_per, m_pend, m_frames, t;
    bit     m_pendv, m_tick;
    longint last_on[N_CH];
    longint last_off[N_CH];
    int unsigned on_v[N_CH];
    int unsigned off_v[N_CH];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_per = DEFP; m_pend = DEFP; m_pendv = 0;
        m_frames = 0; m_tick = 0; t = 1;
        for (int i = 0; i < N_CH; i++) begin
            last_on[i] = 0;
            last_off[i] = 0;
        end
    endtask

    function automatic longint clampv(input longint p);
        return (p < 2) ? 2 : p;
    endfunction

    // Window is open when the latest on-event is strictly newer than the latest off-event.
    task automatic model_step();
        bit   clr;
        bit   boundary;
        exp_t e;
        clr = 0;
        t++;
        if (!en) begin
            m_run = 0; m_cnt = 0; m_tick = 0; clr = 1;
        end else if (!m_run) begin
            if (period_ld) begin m_pend = clampv(longint'(period_in)); m_pendv = 1; end
            m_tick = 0;
            clr = 1;
            if (!mode || trig) begin m_run = 1; m_cnt = 0; m_tick = 1; end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (longint'(on_v[i]) == m_cnt) last_on[i] = t;
                if (longint'(off_v[i]) == m_cnt) last_off[i] = t;
            end
            if (period_ld) begin m_pend = clampv(longint'(period_in)); m_pendv = 1; end
            boundary = (m_cnt == m_per - 1);
            if (boundary || (trig && !mode)) begin
                if (m_pendv) m_per = m_pend;
                m_pendv = 0;
                m_cnt = 0;
                m_tick = 1;
                if (boundary) m_frames = (m_frames + 1) % 65536;
                else clr = 1;
                if (boundary && mode) begin m_run = 0; m_tick = 0; clr = 1; end
            end else begin
                m_cnt++;
                m_tick = 0;
            end
        end
        if (clr) begin
            for (int i = 0; i < N_CH; i++) begin
                last_on[i] = 0;
                last_off[i] = 0;
            end
        end
        for (int i = 0; i < N_CH; i++) e.ch[i] = (last_on[i] > last_off[i]);
        e.tick = m_tick; e.busy = m_run; e.fc = m_frames; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Drives one cycle of inputs, then returns just after the following negedge.
    task automatic step(input bit e, input bit md, input bit tr, input bit ld, input int unsigned pin);
        en = e; mode = md; trig = tr; period_ld = ld; period_in = pin;
        for (int i = 0; i < N_CH; i++) begin
            ch_on[i*CNT_W +: CNT_W]  = on_v[i];
            ch_off[i*CNT_W +: CNT_W] = off_v[i];
        end
        model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("ch_out", longint'(ch_out), longint'(x.ch));
            chk("frame_tick", longint'(frame_tick), longint'(x.tick));
            chk("busy", longint'(busy), longint'(x.busy));
            chk("frame_cnt", longint'(frame_cnt), x.fc);
            chk("cur_cnt", longint'(cur_cnt), x.cnt);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ch"}, longint'(ch_out), 0);
        chk({tag, "_tick"}, longint'(frame_tick), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_fc"}, longint'(frame_cnt), 0);
        chk({tag, "_cnt"}, longint'(cur_cnt), 0);
    endtask

    initial begin
        int busy_n, tick_n;
        longint fc_hold;
        bit md;
        on_v[0] = 2; off_v[0] = 5;
        on_v[1] = 8; off_v[1] = 1;
        on_v[2] = 4; off_v[2] = 4;
        on_v[3] = 20; off_v[3] = 3;
        model_reset();
        #3;
        chk_all_zero("reset");
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;

        // First frame uses the reset period; the load applies from the next frame.
        step(1, 0, 0, 1, 10);
        for (int k = 1; k <= 40; k++) step(1, 0, 0, 0, 0);
        chk("first_frame_fc", longint'(frame_cnt), 1);
        chk("first_frame_cnt", longint'(cur_cnt), 0);
        chk("first_frame_tick", longint'(frame_tick), 1);
        for (int k = 0; k < 30; k++) step(1, 0, 0, 0, 0);
        chk("p10_fc", longint'(frame_cnt), 4);

        // Window shapes over one period-10 frame.
        for (int j = 1; j <= 10; j++) begin
            int c;
            step(1, 0, 0, 0, 0);
            c = j % 10;
            chk("win0", longint'(ch_out[0]), longint'(c >= 3 && c <= 5));
            chk("win1", longint'(ch_out[1]), longint'(c >= 9 || c <= 1));
            chk("win2", longint'(ch_out[2]), 0);
        end

        // One-shot: let the running frame finish, then two triggered frames.
        for (int k = 0; k < 12; k++) step(1, 1, 0, 0, 0);
        chk("oneshot_idle_busy", longint'(busy), 0);
        for (int rep = 0; rep < 2; rep++) begin
            busy_n = 0; tick_n = 0;
            step(1, 1, 1, 0, 0);
            busy_n += busy; tick_n += frame_tick;
            for (int k = 0; k < 13; k++) begin
                step(1, 1, 0, 0, 0);
                busy_n += busy; tick_n += frame_tick;
            end
            chk("oneshot_busy_len", busy_n, 10);
            chk("oneshot_ticks", tick_n, 1);
            chk("oneshot_ch", longint'(ch_out), 0);
            chk("oneshot_fc", longint'(frame_cnt), 7 + rep);
        end

        // Free-run resync at count 6.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("resync_cnt", longint'(cur_cnt), 0);
        chk("resync_tick", longint'(frame_tick), 1);
        chk("resync_ch", longint'(ch_out), 0);
        chk("resync_fc", longint'(frame_cnt), 8);

        // Period load mid-frame never shortens the current frame.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 4);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
        chk("ld_pre_wrap_cnt", longint'(cur_cnt), 9);
        step(1, 0, 0, 0, 0);
        chk("ld_wrap_tick", longint'(frame_tick), 1);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0);
        chk("p4_tick", longint'(frame_tick), 1);
        step(1, 0, 0, 1, 1);
        for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 0);

        // Enable drop mid-frame, then restart.
        step(1, 0, 0, 1, 10);
        for (int k = 0; k < 14; k++) step(1, 0, 0, 0, 0);
        fc_hold = m_frames;
        step(0, 0, 1, 1, 7);
        chk("en_low_busy", longint'(busy), 0);
        chk("en_low_cnt", longint'(cur_cnt), 0);
        chk("en_low_ch", longint'(ch_out), 0);
        chk("en_low_fc", longint'(frame_cnt), fc_hold);
        step(1, 0, 0, 0, 0);
        chk("restart_tick", longint'(frame_tick), 1);
        chk("restart_cnt", longint'(cur_cnt), 0);
        for (int k = 0; k < 7; k++) step(1, 0, 0, 0, 0);

        // Asynchronous reset mid-frame.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        model_reset();
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
        step(1, 0, 0, 0, 0);
        chk("rst_restart_tick", longint'(frame_tick), 1);
        chk("rst_restart_cnt", longint'(cur_cnt), 0);

        // Randomised traffic.
        md = 0;
        for (int k = 0; k < 800; k++) begin
            bit e, tr, ld;
            if ($urandom_range(0, 99) < 3) md = ~md;
            if ($urandom_range(0, 99) < 4) begin
                int i;
                i = $urandom_range(0, N_CH - 1);
                on_v[i] = $urandom_range(0, 13);
                off_v[i] = $urandom_range(0, 13);
            end
            e  = ($urandom_range(0, 99) >= 4);
            tr = ($urandom_range(0, 99) < 10);
            ld = ($urandom_range(0, 99) < 6);
            step(e, md, tr, ld, $urandom_range(0, 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
